// File: rtl/wishbone_master_pkg.sv
// ============================================================================
// Module  : wishbone_master_pkg
// Brief   : Shared types and constants for the Wishbone master port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wishbone_master_pkg;

    localparam int unsigned c_DEFAULT_ADDR_W  = 32;
    localparam int unsigned c_DEFAULT_DATA_W  = 32;
    localparam int unsigned c_DEFAULT_TIMEOUT = 16;

    // Base of the NN FIFO window served by the wishbone_nn slave
    localparam logic [31:0] c_NN_FIFO_BASE = 32'h3000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_e;

endpackage : wishbone_master_pkg

`default_nettype wire

// File: rtl/wb_timeout_counter.sv
// ============================================================================
// Module  : wb_timeout_counter
// Brief   : Saturating bus-cycle timeout counter for the Wishbone master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the edge on which an enabled increment reaches the limit, so the
    // owner can abort on that same edge rather than one cycle later.
    assign expired = (r_count == c_LIMIT) ||
                     (enable && (r_count == (c_LIMIT - 1'b1)));

endmodule : wb_timeout_counter

`default_nettype wire

// File: rtl/wishbone_master_port.sv
// ============================================================================
// Module  : wishbone_master_port
// Brief   : Single-outstanding Wishbone classic master bridging a valid/ready
//           command stream to bus cycles and back to a response stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_master_port
    import wishbone_master_pkg::*;
#(
    parameter int ADDR_W         = c_DEFAULT_ADDR_W,
    parameter int DATA_W         = c_DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [DATA_W-1:0]   resp_dat_o,
    output logic                resp_timeout_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic                wbm_ack_i,
    input  logic [DATA_W-1:0]   wbm_dat_i
);

    wbm_state_e r_state;
    logic       w_cnt_clear;
    logic       w_cnt_enable;
    logic       w_expired;

    // The count restarts every idle cycle, so each bus cycle begins from zero
    assign w_cnt_clear  = (r_state == ST_IDLE);
    assign w_cnt_enable = (r_state == ST_BUS) && !wbm_ack_i;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_enable),
        .expired (w_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state        <= ST_IDLE;
            cmd_ready_o    <= 1'b1;
            resp_valid_o   <= 1'b0;
            resp_dat_o     <= '0;
            resp_timeout_o <= 1'b0;
            wbm_cyc_o      <= 1'b0;
            wbm_stb_o      <= 1'b0;
            wbm_we_o       <= 1'b0;
            wbm_adr_o      <= '0;
            wbm_dat_o      <= '0;
            wbm_sel_o      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_we_o    <= cmd_we_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        r_state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack takes priority over a timeout landing on the same edge
                    if (wbm_ack_i) begin
                        wbm_cyc_o      <= 1'b0;
                        wbm_stb_o      <= 1'b0;
                        resp_dat_o     <= wbm_we_o ? '0 : wbm_dat_i;
                        resp_timeout_o <= 1'b0;
                        resp_valid_o   <= 1'b1;
                        r_state        <= ST_RESP;
                    end else if (w_expired) begin
                        wbm_cyc_o      <= 1'b0;
                        wbm_stb_o      <= 1'b0;
                        resp_dat_o     <= '0;
                        resp_timeout_o <= 1'b1;
                        resp_valid_o   <= 1'b1;
                        r_state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        cmd_ready_o  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    wbm_cyc_o    <= 1'b0;
                    wbm_stb_o    <= 1'b0;
                    resp_valid_o <= 1'b0;
                    cmd_ready_o  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : wishbone_master_port

`default_nettype wire

// File: tb/tb_wishbone_master_port.sv
// ============================================================================
// Module  : tb_wishbone_master_port
// Brief   : Randomized scoreboard bench for wishbone_master_port with a
//           latency-programmable memory slave and a reference response model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wishbone_master_port;
    import wishbone_master_pkg::*;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        resp_valid, resp_ready, resp_timeout;
    logic [31:0] resp_dat;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        ack;

    wishbone_master_port #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_we_i       (cmd_we),
        .cmd_adr_i      (cmd_adr),
        .cmd_dat_i      (cmd_dat),
        .cmd_sel_i      (cmd_sel),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_dat_o     (resp_dat),
        .resp_timeout_o (resp_timeout),
        .wbm_cyc_o      (cyc),
        .wbm_stb_o      (stb),
        .wbm_we_o       (we),
        .wbm_adr_o      (adr),
        .wbm_dat_o      (wdat),
        .wbm_sel_o      (sel),
        .wbm_ack_i      (ack),
        .wbm_dat_i      (rdat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dat;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    int          lat_q[$];
    int          wid_q[$];
    logic [31:0] model_mem [4];
    logic [31:0] slave_mem [4];
    int          errors = 0;
    int          checks = 0;
    bit          hold_next = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Offer one command; d is the ack latency in stb cycles the slave will use.
    task automatic issue(input bit w, input int idx, input logic [31:0] d32,
                         input logic [3:0] s, input int d, input bit expect_resp);
        exp_t e;
        int   n;
        if (expect_resp) begin
            if (d <= c_TO) begin
                e.to  = 1'b0;
                e.dat = w ? 32'h0 : model_mem[idx];
                if (w) model_mem[idx] = merge(model_mem[idx], d32, s);
            end else begin
                e.to  = 1'b1;
                e.dat = 32'h0;
            end
            exp_q.push_back(e);
            wid_q.push_back((d <= c_TO) ? d : c_TO);
        end
        lat_q.push_back(d);
        cmd_we    = w;
        cmd_adr   = c_NN_FIFO_BASE + 32'(idx * 4);
        cmd_dat   = d32;
        cmd_sel   = s;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("cmd_accept_timeout", 64'(n), 64'(0));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Memory slave: acks on the d-th stb cycle, otherwise drives garbage and stray acks.
    int cnt = 0;
    int cur_d = 0;
    always @(negedge clk) begin
        if (rst) begin
            cnt = 0;
            ack = 1'b0;
        end else if (cyc && stb) begin
            if (cnt == 0) begin
                if (lat_q.size() == 0) begin
                    check("unexpected_bus_cycle", 64'(1), 64'(0));
                    cur_d = 1000;
                end else begin
                    cur_d = lat_q.pop_front();
                end
            end
            cnt++;
            rdat = $urandom;
            if (cnt == cur_d) begin
                ack = 1'b1;
                if (we) slave_mem[adr[3:2]] = merge(slave_mem[adr[3:2]], wdat, sel);
                else    rdat = slave_mem[adr[3:2]];
            end else begin
                ack = 1'b0;
            end
        end else begin
            if (cnt != 0) begin
                if (wid_q.size() == 0) check("stb_width_unexpected", 64'(cnt), 64'(0));
                else check("stb_width", 64'(cnt), 64'(wid_q.pop_front()));
                cnt = 0;
            end
            ack  = (($urandom % 6) == 0);
            rdat = $urandom;
        end
    end

    // Response monitor and consumer.
    bit          seen = 1'b0;
    int          hold_cnt = 0;
    logic [32:0] held;
    always @(negedge clk) begin
        if (rst) begin
            seen       = 1'b0;
            resp_ready = 1'b0;
        end else if (resp_valid) begin
            check("cyc_low_in_resp", 64'(cyc), 64'(0));
            check("cmd_ready_low_in_resp", 64'(cmd_ready), 64'(0));
            if (!seen) begin
                seen = 1'b1;
                held = {resp_dat, resp_timeout};
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 64'(1), 64'(0));
                end else begin
                    check("resp_dat", 64'(resp_dat), 64'(exp_q[0].dat));
                    check("resp_timeout", 64'(resp_timeout), 64'(exp_q[0].to));
                end
                if (hold_next) begin
                    hold_next = 1'b0;
                    hold_cnt  = 5;
                end
            end else begin
                check("resp_stable", 64'({resp_dat, resp_timeout}), 64'(held));
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
                resp_ready = 1'b0;
            end else begin
                resp_ready = (($urandom % 3) != 0);
            end
            if (resp_ready) begin
                seen = 1'b0;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end else begin
            resp_ready = $urandom % 2;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit w;
        int d;
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = 32'h0;
            slave_mem[i] = 32'h0;
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        resp_ready = 1'b0; ack = 1'b0; rdat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_cyc_stb_we", 64'({cyc, stb, we}), 64'(0));
        check("rst_adr_dat_sel", {adr, wdat ^ {28'h0, sel}}, 64'(0));
        check("rst_resp_fields", 64'({resp_dat, resp_timeout}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        issue(1'b1, 0, 32'hDEADABBA, 4'hF, 2, 1'b1);
        issue(1'b1, 1, 32'h0000ABBA, 4'hF, 1, 1'b1);
        issue(1'b1, 2, 32'hDEAD0000, 4'hF, 3, 1'b1);
        issue(1'b0, 1, 32'h0, 4'hF, 1, 1'b1);
        issue(1'b0, 2, 32'h0, 4'hF, 2, 1'b1);
        issue(1'b0, 0, 32'h0, 4'hF, 1, 1'b1);
        issue(1'b0, 0, 32'h0, 4'hF, 40, 1'b1);      // no ack at all
        issue(1'b0, 2, 32'h0, 4'hF, c_TO, 1'b1);    // ack on the expiry edge
        issue(1'b0, 1, 32'h0, 4'hF, c_TO + 1, 1'b1);
        hold_next = 1'b1;
        issue(1'b0, 1, 32'h0, 4'hF, 2, 1'b1);
        issue(1'b1, 3, 32'h12345678, 4'h5, 1, 1'b1);

        for (int i = 0; i < 200; i++) begin
            w = $urandom % 2;
            d = (($urandom % 10) == 0) ? $urandom_range(c_TO - 2, c_TO + 3) : $urandom_range(1, 5);
            issue(w, $urandom_range(0, 3), $urandom, 4'($urandom), d, 1'b1);
            if (($urandom % 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_responses", 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk);

        issue(1'b0, 0, 32'h0, 4'hF, 1000, 1'b0);
        repeat (3) @(negedge clk);
        check("bus_active_before_reset", 64'({cyc, stb}), 64'(3));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_cyc_stb", 64'({cyc, stb}), 64'(0));
        check("mid_reset_resp_valid", 64'(resp_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (4) @(negedge clk);
        check("post_reset_no_resp", 64'({resp_valid, cyc}), 64'(0));
        check("latency_queue_consumed", 64'(lat_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wishbone_master_port

`default_nettype wire
